// File: rtl/flex_host_ctrl.sv
// Host-side sequencer for the FLEX pad interface: turns WRITE/READ/EXEC commands into
// correctly phased pad strobes and returns exactly one response per accepted command.
module flex_host_ctrl #(
    parameter int unsigned RD_TIMEOUT   = 64,
    parameter int unsigned EXEC_TIMEOUT = 1048576
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_data,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] exec_cycles,

    output logic [15:0] pad_data,
    output logic [19:0] pad_addr,
    output logic        pad_rw,
    output logic [1:0]  pad_dav,
    output logic        pad_start,
    output logic        pad_chip_en,
    input  logic [15:0] pad_rdata,
    input  logic        pad_rvalid,
    input  logic        pad_exec_end
);

    localparam logic [31:0] RdLimit = 32'(RD_TIMEOUT);
    localparam logic [31:0] ExLimit = 32'(EXEC_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdReq,
        StRdWait,
        StExStart,
        StExWait,
        StRsp
    } state_e;

    state_e      state_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_inc;

    // Shared wait counter; saturates so a very long EXEC never wraps back to a small count.
    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            exec_cycles <= '0;
            pad_data    <= '0;
            pad_addr    <= '0;
            pad_rw      <= 1'b0;
            pad_dav     <= 2'b00;
            pad_start   <= 1'b0;
            pad_chip_en <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready   <= 1'b0;
                        pad_chip_en <= 1'b1;
                        case (cmd_op)
                            2'b00: begin
                                state_q  <= StWr;
                                pad_addr <= cmd_addr;
                                pad_data <= cmd_data;
                                pad_rw   <= 1'b1;
                                pad_dav  <= 2'b11;
                            end
                            2'b01: begin
                                state_q  <= StRdReq;
                                pad_addr <= cmd_addr;
                                pad_rw   <= 1'b0;
                                pad_dav  <= 2'b01;
                            end
                            2'b10: begin
                                state_q   <= StExStart;
                                pad_start <= 1'b1;
                            end
                            default: begin
                                state_q   <= StRsp;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                StWr: begin
                    state_q   <= StRsp;
                    pad_addr  <= '0;
                    pad_data  <= '0;
                    pad_rw    <= 1'b0;
                    pad_dav   <= 2'b00;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                StRdReq: begin
                    state_q  <= StRdWait;
                    pad_addr <= '0;
                    pad_dav  <= 2'b00;
                    cnt_q    <= '0;
                end
                StRdWait: begin
                    cnt_q <= cnt_inc;
                    // A late rvalid landing on the final wait cycle still counts as success.
                    if (pad_rvalid) begin
                        state_q   <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_data  <= pad_rdata;
                        rsp_err   <= 1'b0;
                    end else if (cnt_inc == RdLimit) begin
                        state_q   <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                StExStart: begin
                    state_q   <= StExWait;
                    pad_start <= 1'b0;
                    cnt_q     <= '0;
                end
                StExWait: begin
                    cnt_q <= cnt_inc;
                    if (pad_exec_end) begin
                        state_q     <= StRsp;
                        exec_cycles <= cnt_inc;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= cnt_inc[15:0];
                        rsp_err     <= 1'b0;
                    end else if (cnt_inc == ExLimit) begin
                        state_q     <= StRsp;
                        exec_cycles <= ExLimit;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= ExLimit[15:0];
                        rsp_err     <= 1'b1;
                    end
                end
                StRsp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid   <= 1'b0;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        pad_chip_en <= 1'b0;
                        cmd_ready   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_host_ctrl.sv
// Self-checking bench for flex_host_ctrl: directed corner cases followed by random commands,
// each checked against a latency/result model derived from the command rules.
module tb_flex_host_ctrl;

    localparam int unsigned RdTo = 64;
    localparam int unsigned ExTo = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [31:0] exec_cycles;
    logic [15:0] pad_data;
    logic [19:0] pad_addr;
    logic        pad_rw;
    logic [1:0]  pad_dav;
    logic        pad_start;
    logic        pad_chip_en;
    logic [15:0] pad_rdata;
    logic        pad_rvalid;
    logic        pad_exec_end;

    flex_host_ctrl #(
        .RD_TIMEOUT  (RdTo),
        .EXEC_TIMEOUT(ExTo)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .exec_cycles (exec_cycles),
        .pad_data    (pad_data),
        .pad_addr    (pad_addr),
        .pad_rw      (pad_rw),
        .pad_dav     (pad_dav),
        .pad_start   (pad_start),
        .pad_chip_en (pad_chip_en),
        .pad_rdata   (pad_rdata),
        .pad_rvalid  (pad_rvalid),
        .pad_exec_end(pad_exec_end)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_exec = 32'd0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 32'({cmd_ready, rsp_valid, rsp_err, pad_rw, pad_start, pad_chip_en,
                                  pad_dav}), 32'h80);
        check({tag, "_data"}, {pad_data, rsp_data}, 32'd0);
        check({tag, "_addr"}, 32'(pad_addr), 32'd0);
        check({tag, "_exec"}, exec_cycles, exp_exec);
    endtask

    // d: cycle index within the wait phase at which the chip answers (-1 = never).
    task automatic run_cmd(input logic [1:0] op, input logic [19:0] addr, input logic [15:0] data,
                           input int d, input logic [15:0] rdata, input int hold);
        int          exp_k;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [31:0] new_exec;
        int          k;
        bit          seen;
        bit          en_ok;
        bit          strobe_ok;
        int          n11, n01, nst;
        logic [15:0] got_data;
        logic        got_err;
        bit          stable;

        new_exec = exp_exec;
        exp_data = 16'h0;
        case (op)
            2'b00: begin
                exp_k   = 2;
                exp_err = 1'b0;
            end
            2'b01: begin
                if (d >= 0 && d < int'(RdTo)) begin
                    exp_k    = 3 + d;
                    exp_data = rdata;
                    exp_err  = 1'b0;
                end else begin
                    exp_k   = 2 + int'(RdTo);
                    exp_err = 1'b1;
                end
            end
            2'b10: begin
                if (d >= 0 && d < int'(ExTo)) begin
                    exp_k    = 3 + d;
                    new_exec = 32'(d + 1);
                    exp_err  = 1'b0;
                end else begin
                    exp_k    = 2 + int'(ExTo);
                    new_exec = ExTo;
                    exp_err  = 1'b1;
                end
                exp_data = new_exec[15:0];
            end
            default: begin
                exp_k   = 1;
                exp_err = 1'b1;
            end
        endcase

        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 20'($urandom);
        cmd_data  = 16'($urandom);

        k         = 1;
        seen      = 1'b0;
        en_ok     = 1'b1;
        strobe_ok = 1'b1;
        n11       = 0;
        n01       = 0;
        nst       = 0;
        while (!seen && k <= exp_k + 8) begin
            if (rsp_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (pad_chip_en !== 1'b1) en_ok = 1'b0;
                if (pad_dav === 2'b11) begin
                    n11++;
                    if (k != 1 || pad_rw !== 1'b1 || pad_addr !== addr || pad_data !== data)
                        strobe_ok = 1'b0;
                end
                if (pad_dav === 2'b01) begin
                    n01++;
                    if (k != 1 || pad_rw !== 1'b0 || pad_addr !== addr) strobe_ok = 1'b0;
                end
                if (pad_start === 1'b1) begin
                    nst++;
                    if (k != 1) strobe_ok = 1'b0;
                end
                pad_rvalid   = (op == 2'b01 && d >= 0 && k == 2 + d);
                pad_exec_end = (op == 2'b10 && d >= 0 && k == 2 + d);
                pad_rdata    = (k == 2 + d) ? rdata : 16'($urandom);
                tick();
                k++;
            end
        end
        pad_rvalid   = 1'b0;
        pad_exec_end = 1'b0;

        check("rsp_latency", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_k));
        check("chip_en_busy", 32'(en_ok), 32'd1);
        check("strobe_counts", {8'h0, 8'(n11), 8'(n01), 8'(nst)},
              {8'h0, 8'(op == 2'b00), 8'(op == 2'b01), 8'(op == 2'b10)});
        check("strobe_content", 32'(strobe_ok), 32'd1);

        if (seen) begin
            check("rsp_data", 32'(rsp_data), 32'(exp_data));
            check("rsp_err", 32'(rsp_err), 32'(exp_err));
            check("exec_cycles", exec_cycles, new_exec);
            exp_exec = new_exec;
            got_data = rsp_data;
            got_err  = rsp_err;
            stable   = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (rsp_valid !== 1'b1 || rsp_data !== got_data || rsp_err !== got_err ||
                    cmd_ready !== 1'b0 || pad_chip_en !== 1'b1 || pad_dav !== 2'b00 ||
                    pad_start !== 1'b0)
                    stable = 1'b0;
            end
            check("rsp_hold_stable", 32'(stable), 32'd1);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check_idle("back_to_idle");
        end else begin
            rst = 1'b1;
            tick();
            rst      = 1'b0;
            exp_exec = 32'd0;
        end
    endtask

    task automatic reset_mid(input logic [1:0] op, input int wait_cycles);
        bit quiet;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = 20'($urandom);
        cmd_data  = 16'($urandom);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        exp_exec = 32'd0;
        check_idle("reset_mid");
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        check("reset_no_rsp", 32'(quiet), 32'd1);
    endtask

    initial begin
        int          op_r;
        int          d_r;
        logic [15:0] rd_r;

        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_addr     = '0;
        cmd_data     = '0;
        rsp_ready    = 1'b0;
        pad_rdata    = '0;
        pad_rvalid   = 1'b0;
        pad_exec_end = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("after_reset");

        run_cmd(2'b00, 20'h12345, 16'hBEEF, 0, 16'h0, 0);
        run_cmd(2'b01, 20'h00040, 16'h0, 2, 16'hA5A5, 1);
        run_cmd(2'b01, 20'h00041, 16'h0, -1, 16'h0, 0);
        run_cmd(2'b01, 20'h00042, 16'h0, int'(RdTo) - 1, 16'h5A5A, 0);
        run_cmd(2'b01, 20'h00043, 16'h0, int'(RdTo), 16'h1234, 0);
        run_cmd(2'b10, 20'h0, 16'h0, 99, 16'h0, 0);
        run_cmd(2'b10, 20'h0, 16'h0, -1, 16'h0, 2);
        run_cmd(2'b10, 20'h0, 16'h0, 0, 16'h0, 0);
        run_cmd(2'b10, 20'h0, 16'h0, int'(ExTo) - 1, 16'h0, 0);
        run_cmd(2'b11, 20'hFFFFF, 16'hFFFF, 0, 16'h0, 5);

        reset_mid(2'b01, 6);
        run_cmd(2'b10, 20'h0, 16'h0, 30, 16'h0, 0);
        reset_mid(2'b10, 10);
        run_cmd(2'b00, 20'hABCDE, 16'h1357, 0, 16'h0, 0);

        for (int n = 0; n < 40; n++) begin
            op_r = int'($urandom_range(0, 3));
            rd_r = 16'($urandom);
            if (op_r == 1)
                d_r = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, RdTo + 3));
            else if (op_r == 2)
                d_r = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, ExTo + 3));
            else
                d_r = 0;
            run_cmd(2'(op_r), 20'($urandom), 16'($urandom), d_r, rd_r,
                    int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flex_host_ctrl.md
# flex_host_ctrl

Host-side sequencer for the FLEX pad interface. Accepts single-word WRITE, READ and EXEC commands over a valid/ready port and drives the chip's data/address/strobe pins with the correct phase ordering. Waits for the chip's `data_out_valid` or `exec_end` and returns one response per command, with timeout error reporting. Sits between the test host (FPGA/bench) and the chip boundary, feeding the pad-level inputs directly.

## Interface
Parameters:
- `RD_TIMEOUT`, 64: maximum RD_WAIT cycles before a read error.
- `EXEC_TIMEOUT`, 1048576: maximum EX_WAIT cycles before an exec error.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 WRITE, 01 READ, 10 EXEC, 11 illegal.
- `cmd_addr` in 20: target address.
- `cmd_data` in 16: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed on `rsp_valid && rsp_ready`.
- `rsp_data` out 16: read data (READ), `exec_cycles[15:0]` (EXEC), 0 otherwise.
- `rsp_err` out 1: timeout or illegal op.
- `exec_cycles` out 32: cycle count of the last EXEC.
- `pad_data` out 16: to chip `data_in`.
- `pad_addr` out 20: to chip `address_in`.
- `pad_rw` out 1: 1 = write, 0 = read.
- `pad_dav` out 2: to chip `data_addr_valid`. bit0 = address valid, bit1 = data valid.
- `pad_start` out 1: to chip `scan_start_exec`.
- `pad_chip_en` out 1: to chip `chip_en`.
- `pad_rdata` in 16: from chip `data_out`.
- `pad_rvalid` in 1: from chip `data_out_valid`.
- `pad_exec_end` in 1: from chip `exec_end`.

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, EX_START, EX_WAIT, RSP.
- **IDLE**
  - `cmd_ready` = 1. All other outputs are at their reset values, except `exec_cycles`, which holds its last value.
  - On accept, latch op/addr/data and go to: WR (00), RD_REQ (01), EX_START (10), or RSP with `rsp_err` = 1 (11).
- **WR** (1 cycle)
  - `pad_addr`/`pad_data` = latched values, `pad_rw` = 1, `pad_dav` = 11.
  - Then RSP with `rsp_err` = 0, `rsp_data` = 0.
- **RD_REQ** (1 cycle)
  - `pad_addr` = latched address, `pad_rw` = 0, `pad_dav` = 01.
  - Then RD_WAIT with the wait counter cleared.
- **RD_WAIT**
  - `pad_dav` = 00. The counter increments each cycle.
  - On `pad_rvalid` = 1: capture `pad_rdata`, `rsp_err` = 0, go to RSP.
  - Otherwise, when the counter reaches `RD_TIMEOUT`: `rsp_data` = 0, `rsp_err` = 1, go to RSP.
  - `pad_rvalid` is sampled only in RD_WAIT. If rvalid and the timeout coincide, rvalid wins.
- **EX_START** (1 cycle)
  - `pad_start` = 1. Clear the 32-bit cycle counter, then go to EX_WAIT.
- **EX_WAIT**
  - The counter increments every cycle, saturating at 2^32-1.
  - On `pad_exec_end` = 1: `exec_cycles` = count including this cycle (minimum 1), `rsp_data` = `exec_cycles[15:0]`, `rsp_err` = 0, go to RSP.
  - On count = `EXEC_TIMEOUT` without exec_end: `rsp_err` = 1, `exec_cycles` = `EXEC_TIMEOUT`, go to RSP. If end and timeout coincide, end wins.
- **RSP**
  - `rsp_valid` = 1. `rsp_data`/`rsp_err` are stable while `rsp_valid` is high.
  - On `rsp_ready`, return to IDLE. `rsp_ready` may already be high on the first RSP cycle.
- `pad_chip_en` = 1 in every non-IDLE state. It rises in the first cycle after accept.
- Reset in any state forces IDLE on the next edge. Any in-flight command is discarded with no response.

## Timing
- Reset values:
  - `cmd_ready` = 1 (in IDLE after reset).
  - `rsp_valid`, `rsp_err`, `pad_rw`, `pad_start`, `pad_chip_en` = 0.
  - `pad_dav` = 00; `pad_data`, `pad_addr`, `rsp_data` = 0; `exec_cycles` = 0.
- All outputs are registered; no combinational paths from input to output.
- WRITE: accept at cycle T, pad strobe at T+1, `rsp_valid` at T+2. Minimum 3 cycles per command, including the return to IDLE.
- READ: accept T, `pad_dav` = 01 at T+1, RD_WAIT from T+2. With rvalid first seen at cycle R, `rsp_valid` is at R+1.
- EXEC: accept T, `pad_start` at T+1, EX_WAIT from T+2. With exec_end first seen at cycle E, `rsp_valid` is at E+1 and `exec_cycles` = E-(T+1).
- Back-to-back: the next command can be accepted one cycle after the rsp handshake.

## Test plan
- WRITE addr 0x12345 data 0xBEEF -> exactly one cycle of `pad_dav` = 11, `pad_rw` = 1, addr/data match; rsp_data 0, rsp_err 0 at T+2.
- READ addr 0x00040, chip model returns 0xA5A5 three cycles after the request -> `rsp_data` = 0xA5A5, err 0; `pad_dav` = 01 for one cycle only.
- READ with no rvalid -> `rsp_err` = 1, `rsp_data` = 0 after exactly `RD_TIMEOUT` wait cycles. Rvalid on the timeout cycle -> no error.
- EXEC with exec_end at start+100 cycles -> `exec_cycles` = 100, `rsp_data` = 100, `pad_start` pulse one cycle. With `EXEC_TIMEOUT` = 16 and no end -> err 1, `exec_cycles` = 16.
- Illegal op 11 -> response with err 1 and no pad activity. `rsp_ready` held low 5 cycles -> response stable, `cmd_ready` = 0 throughout.
- `rst` asserted mid-RD_WAIT and mid-EX_WAIT -> next cycle IDLE, all outputs at reset values, no `rsp_valid`; a following WRITE completes normally.
